// File: rtl/uart_pkg.sv
// Shared UART definitions: frame state encoding and the parity helper used by
// the rx/tx engines and their benches.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    BREAK  = 3'd5
  } uart_state_e;

  // Expected parity bit for up to 9 data bits; narrower words are zero-extended,
  // which leaves the XOR unchanged.
  function automatic logic parity_bit(input logic [8:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_sync.sv
// Multi-stage synchroniser for an asynchronous idle-high line; all stages
// reset to 1 so no spurious falling edge appears coming out of reset.
module uart_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= '1;
    else     sync_q <= {sync_q[STAGES-2:0], d_i};
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/uart_rx_engine.sv
// UART receive engine: validated start bit, mid-bit oversampled data, optional
// parity, 1 or 2 stop bits, framing/parity error reporting and break handling.
module uart_rx_engine
  import uart_pkg::*;
#(
  parameter int DATA_BITS   = 8,
  parameter int OVERSAMPLE  = 16,
  parameter int PARITY_EN   = 0,
  parameter int PARITY_ODD  = 0,
  parameter int STOP_BITS   = 1,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  input  logic                 tick,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 valid,
  output logic                 parity_err,
  output logic                 framing_err,
  output logic                 busy,
  output logic                 sample
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [TW-1:0] HALF_LAST = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] OS_LAST   = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);
  localparam logic          ODD       = (PARITY_ODD != 0);
  localparam bit            HAS_PAR   = (PARITY_EN != 0);

  logic                 rx_s;
  uart_state_e          state_q, state_d;
  logic [TW-1:0]        tick_cnt_q, tick_cnt_d;
  logic [BW-1:0]        bit_cnt_q, bit_cnt_d;
  logic                 par_err_q, par_err_d;
  logic                 frm_err_q, frm_err_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 perr_q, perr_d;
  logic                 ferr_q, ferr_d;
  logic                 valid_q, valid_d;
  logic                 sample_q, sample_d;
  logic [DATA_BITS-1:0] shift_q;
  logic                 shift_en;

  uart_sync #(.STAGES(SYNC_STAGES)) u_sync (
    .clk (clk),
    .rst (rst),
    .d_i (rx),
    .q_o (rx_s)
  );

  always_comb begin
    state_d    = state_q;
    tick_cnt_d = tick_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    par_err_d  = par_err_q;
    frm_err_d  = frm_err_q;
    data_d     = data_q;
    perr_d     = perr_q;
    ferr_d     = ferr_q;
    valid_d    = 1'b0;
    sample_d   = 1'b0;
    shift_en   = 1'b0;
    if (tick) begin
      tick_cnt_d = tick_cnt_q + 1'b1;
      case (state_q)
        IDLE: begin
          tick_cnt_d = '0;
          if (!rx_s) state_d = START;
        end
        // Start validation is not reported on sample; a high line here is a glitch.
        START: if (tick_cnt_q == HALF_LAST) begin
          tick_cnt_d = '0;
          bit_cnt_d  = '0;
          par_err_d  = 1'b0;
          frm_err_d  = 1'b0;
          state_d    = rx_s ? IDLE : DATA;
        end
        DATA: if (tick_cnt_q == OS_LAST) begin
          tick_cnt_d = '0;
          sample_d   = 1'b1;
          shift_en   = 1'b1;
          bit_cnt_d  = bit_cnt_q + 1'b1;
          if (bit_cnt_q == DATA_LAST) begin
            bit_cnt_d = '0;
            state_d   = HAS_PAR ? PARITY : STOP;
          end
        end
        PARITY: if (tick_cnt_q == OS_LAST) begin
          tick_cnt_d = '0;
          sample_d   = 1'b1;
          par_err_d  = parity_bit(9'(shift_q), ODD) != rx_s;
          state_d    = STOP;
        end
        STOP: if (tick_cnt_q == OS_LAST) begin
          tick_cnt_d = '0;
          sample_d   = 1'b1;
          frm_err_d  = frm_err_q | ~rx_s;
          bit_cnt_d  = bit_cnt_q + 1'b1;
          if (bit_cnt_q == STOP_LAST) begin
            bit_cnt_d = '0;
            valid_d   = 1'b1;
            data_d    = shift_q;
            perr_d    = HAS_PAR ? par_err_q : 1'b0;
            ferr_d    = frm_err_d;
            state_d   = frm_err_d ? BREAK : IDLE;
          end
        end
        // A line held low after a bad stop bit must not be read as new frames.
        BREAK: begin
          tick_cnt_d = '0;
          if (rx_s) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      tick_cnt_q <= '0;
      bit_cnt_q  <= '0;
      par_err_q  <= 1'b0;
      frm_err_q  <= 1'b0;
      data_q     <= '0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      valid_q    <= 1'b0;
      sample_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      tick_cnt_q <= tick_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      par_err_q  <= par_err_d;
      frm_err_q  <= frm_err_d;
      data_q     <= data_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
      valid_q    <= valid_d;
      sample_q   <= sample_d;
    end
  end

  // LSB arrives first, so after DATA_BITS right-shifts it sits at bit 0.
  always_ff @(posedge clk) begin
    if (shift_en) shift_q <= {rx_s, shift_q[DATA_BITS-1:1]};
  end

  assign data_out    = data_q;
  assign valid       = valid_q;
  assign parity_err  = perr_q;
  assign framing_err = ferr_q;
  assign sample      = sample_q;
  assign busy        = (state_q != IDLE);

endmodule
